// File: rtl/apb2axi_axi_issuer.sv
// AXI4-Lite issuer for the APB-to-AXI bridge.
// Pops one request from the CDC FIFO and runs it on AXI. Only one transaction
// is in flight at a time. The AXI response is then held until the consumer takes it.
module apb2axi_axi_issuer #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W,
  localparam int RSP_W  = 3 + DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_vld,
  input  logic [REQ_W-1:0]  req_data,
  output logic              req_rdy,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  output logic              rsp_vld,
  output logic [RSP_W-1:0]  rsp_data,
  input  logic              rsp_rdy,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RSP
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_strb;
  logic                r_is_write;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_rsp_vld;
  logic [RSP_W-1:0]    r_rsp_data;

  logic                w_req_is_write;
  logic [ADDR_W-1:0]   w_req_addr;
  logic [DATA_W-1:0]   w_req_wdata;
  logic [STRB_W-1:0]   w_req_strb;
  logic                w_aw_fin;
  logic                w_w_fin;

  assign w_req_is_write = req_data[REQ_W-1];
  assign w_req_addr     = req_data[REQ_W-2 -: ADDR_W];
  assign w_req_wdata    = req_data[STRB_W+DATA_W-1 -: DATA_W];
  assign w_req_strb     = req_data[STRB_W-1:0];

  // A channel counts as finished if it was done earlier or handshakes this
  // cycle. This lets WR leave on the same edge as the final handshake.
  assign w_aw_fin = r_aw_done | (r_awvalid & m_axi_awready);
  assign w_w_fin  = r_w_done  | (r_wvalid  & m_axi_wready);

  assign req_rdy       = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_strb;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_araddr  = r_addr;
  assign m_axi_rready  = r_rready;
  assign rsp_vld       = r_rsp_vld;
  assign rsp_data      = r_rsp_data;

  // Transaction FSM with registered AXI valid/ready and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_strb     <= '0;
      r_is_write <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_vld) begin
            r_addr     <= w_req_addr;
            r_wdata    <= w_req_wdata;
            r_strb     <= w_req_strb;
            r_is_write <= w_req_is_write;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            if (w_req_is_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_WR: begin
          if (r_awvalid && m_axi_awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && m_axi_wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            r_rsp_data <= {r_is_write, m_axi_bresp, {DATA_W{1'b0}}};
            r_bready   <= 1'b0;
            r_rsp_vld  <= 1'b1;
            r_state    <= S_RSP;
          end
        end
        S_RD_ADDR: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi_rvalid) begin
            r_rsp_data <= {r_is_write, m_axi_rresp, m_axi_rdata};
            r_rready   <= 1'b0;
            r_rsp_vld  <= 1'b1;
            r_state    <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_rdy) begin
            r_rsp_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb2axi_axi_issuer.sv
// Directed bench for apb2axi_axi_issuer. The stimulus queues each expected
// response. A negedge monitor pops and compares on every rsp handshake.
module tb_apb2axi_axi_issuer;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int RSP_W  = 3 + DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_vld;
  logic [REQ_W-1:0]  req_data;
  logic              req_rdy;
  logic              m_axi_awvalid, m_axi_awready;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic              m_axi_wvalid, m_axi_wready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [STRB_W-1:0] m_axi_wstrb;
  logic              m_axi_bvalid, m_axi_bready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_arvalid, m_axi_arready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_rvalid, m_axi_rready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              rsp_vld;
  logic [RSP_W-1:0]  rsp_data;
  logic              rsp_rdy;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [RSP_W-1:0] exp_q[$];
  logic [RSP_W-1:0] exp_rsp;

  apb2axi_axi_issuer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_rdy(rsp_rdy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle; it must be accepted at that edge.
  task automatic send(input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    req_data = {wr, a, d, s};
    req_vld  = 1'b1;
    chk("req_rdy_before_accept", req_rdy, 1);
    tick();
    req_vld  = 1'b0;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (!reset && rsp_vld && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got %0h expected no response", rsp_data);
      end else begin
        chk("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_vld = 1'b0; req_data = '0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'd0;
    m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'd0;
    rsp_rdy = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_vld}, 0);
    chk("rst_rsp_data", rsp_data, 0);

    // Write with every ready high
    send(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    chk("w1_awvalid", m_axi_awvalid, 1);
    chk("w1_wvalid", m_axi_wvalid, 1);
    chk("w1_awaddr", m_axi_awaddr, 32'h0000_1000);
    chk("w1_wdata", m_axi_wdata, 32'hDEAD_BEEF);
    chk("w1_wstrb", m_axi_wstrb, 4'hF);
    chk("w1_busy_req_rdy", {busy, req_rdy}, 2'b10);
    tick();
    chk("w1_valids_drop", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
    chk("w1_bready", m_axi_bready, 1);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'd0;
    exp_rsp = {1'b1, 2'd0, 32'h0}; exp_q.push_back(exp_rsp);
    tick();
    m_axi_bvalid = 1'b0;
    chk("w1_rsp_vld", rsp_vld, 1);
    chk("w1_bready_off", m_axi_bready, 0);
    tick();
    chk("w1_rsp_vld_one_cycle", rsp_vld, 0);
    chk("w1_idle", {busy, req_rdy}, 2'b01);

    // awready held off for three cycles, wready immediate
    m_axi_awready = 1'b0;
    send(1'b1, 32'h0000_1004, 32'h0102_0304, 4'h3);
    chk("w2_c1", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    tick();
    chk("w2_c2", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
    chk("w2_c2_bready", m_axi_bready, 0);
    tick();
    chk("w2_c3", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
    tick();
    chk("w2_c4", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
    chk("w2_awaddr_hold", m_axi_awaddr, 32'h0000_1004);
    m_axi_awready = 1'b1;
    tick();
    chk("w2_aw_drop", m_axi_awvalid, 0);
    chk("w2_bready", m_axi_bready, 1);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'd0;
    exp_rsp = {1'b1, 2'd0, 32'h0}; exp_q.push_back(exp_rsp);
    tick();
    chk("w2_rsp_vld", rsp_vld, 1);
    chk("w2_second_b_ignored", m_axi_bready, 0);
    tick();
    m_axi_bvalid = 1'b0;
    chk("w2_back_idle", {busy, rsp_vld}, 2'b00);

    // Read with a slow R channel and SLVERR
    send(1'b0, 32'h0000_2000, 32'hAAAA_5555, 4'hF);
    chk("r1_arvalid", m_axi_arvalid, 1);
    chk("r1_araddr", m_axi_araddr, 32'h0000_2000);
    chk("r1_no_write", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
    tick();
    chk("r1_ar_drop", m_axi_arvalid, 0);
    chk("r1_rready", m_axi_rready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r1_wait", {m_axi_rready, rsp_vld}, 2'b10);
    end
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678; m_axi_rresp = 2'd2;
    exp_rsp = {1'b0, 2'd2, 32'h1234_5678}; exp_q.push_back(exp_rsp);
    tick();
    m_axi_rvalid = 1'b0;
    chk("r1_rsp_vld", rsp_vld, 1);
    chk("r1_rready_off", m_axi_rready, 0);
    tick();

    // Consumer stalls; zero-strobe write with DECERR; new request waits
    rsp_rdy = 1'b0;
    send(1'b1, 32'h0000_3004, 32'h0BAD_F00D, 4'h0);
    chk("w3_zero_strb_issued", {m_axi_awvalid, m_axi_wvalid, m_axi_wstrb}, 6'b11_0000);
    tick();
    chk("w3_bready", m_axi_bready, 1);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'd3;
    exp_rsp = {1'b1, 2'd3, 32'h0}; exp_q.push_back(exp_rsp);
    tick();
    m_axi_bvalid = 1'b0;
    req_data = {1'b0, 32'h0000_4000, 32'h0, 4'h0};
    req_vld  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("stall_rsp_vld", rsp_vld, 1);
      chk("stall_rsp_data", rsp_data, {1'b1, 2'd3, 32'h0});
      chk("stall_req_rdy", req_rdy, 0);
      tick();
    end
    rsp_rdy = 1'b1;
    tick();
    chk("stall_idle_req_rdy", req_rdy, 1);
    chk("stall_idle_no_accept_yet", m_axi_arvalid, 0);
    tick();
    req_vld = 1'b0;
    chk("stall_next_accepted", m_axi_arvalid, 1);
    chk("stall_next_araddr", m_axi_araddr, 32'h0000_4000);
    tick();
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hCAFE_F00D; m_axi_rresp = 2'd0;
    exp_rsp = {1'b0, 2'd0, 32'hCAFE_F00D}; exp_q.push_back(exp_rsp);
    tick();
    m_axi_rvalid = 1'b0;
    chk("r2_rsp_vld", rsp_vld, 1);
    tick();

    // Spurious B during a read, then reset while waiting for B
    send(1'b0, 32'h0000_5000, 32'h0, 4'h0);
    tick();
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'd2;
    chk("spur_bready", {m_axi_bready, m_axi_rready}, 2'b01);
    tick();
    chk("spur_bready2", {m_axi_bready, m_axi_rready, rsp_vld}, 3'b010);
    m_axi_bvalid = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1111_2222; m_axi_rresp = 2'd3;
    exp_rsp = {1'b0, 2'd3, 32'h1111_2222}; exp_q.push_back(exp_rsp);
    tick();
    m_axi_rvalid = 1'b0;
    chk("r3_rsp_vld", rsp_vld, 1);
    tick();
    send(1'b1, 32'h0000_6000, 32'h5555_AAAA, 4'hF);
    tick();
    chk("w4_in_wr_resp", m_axi_bready, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_req_rdy", req_rdy, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_vld}, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_addr", m_axi_awaddr, 0);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'd0;
    tick();
    chk("idle_b_ignored", {m_axi_bready, busy, rsp_vld}, 3'b000);
    m_axi_bvalid = 1'b0;
    tick(); tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
